tone_synth: RTL and testbench
=============================

Name: tone_synth

Overview:
- Downstream of the Music note ROM; consumes its 32-bit tone frequency (Hz) and drives the pmod audio pin.
- A sequential divider converts Hz into a half-period count.
- Frequency changes take effect only at a square-wave edge, so note changes are glitch-free.
- Volume is applied by gating the square wave's high phase with a 10-bit carrier PWM.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency; the divider's dividend.
- SILENCE_HZ, 20000: any tone >= this value, or equal to 0, is treated as silence.
- RAMP_CYC, 1_000_000: clk cycles per volume step (used only with SOFT_START_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tone_i  in  32  requested frequency in Hz; level signal, may change on any cycle
- vol_i  in  3  volume; 0 = mute, 7 = maximum
- pwm_o  out  1  audio output to pmod
- sq_o  out  1  raw square wave, before volume gating
- active_o  out  1  a non-silent tone is currently playing
- busy_o  out  1  divider running

Behaviour:
- Reset values (async, rst_n=0):
  - State machine: IDLE.
  - tone_q=0; pend_v=0; half_cnt=0; half_max=0.
  - sq_o=0, pwm_o=0, active_o=0, busy_o=0.
  - Carrier counter car=0.
- Change detection: each cycle, compare tone_i with registered tone_q.
  - If they differ: tone_q<=tone_i and pend_v<=0.
  - If tone_i is silent, set pend_silent.
  - Otherwise enter DIV with divisor = {tone_i,1'b0} (33 bits) and dividend = CLK_HZ.
- States:
  - IDLE: waiting.
  - DIV: restoring divider, one quotient bit per cycle, 32 cycles; busy_o=1.
    - Completion writes pend_max = quotient, clamped to a minimum of 1; sets pend_v=1; returns to IDLE.
    - Latency: change registered at edge k, pend_v=1 at edge k+33.
  - A tone change during DIV restarts the divider at bit 31; no partial result is ever used.
  - A tone change on the same cycle DIV completes discards the result and restarts.
- Wave generator (runs in parallel with the state machine):
  - While active_o=1: half_cnt counts 0..half_max-1; at wrap, half_cnt<=0 and sq_o toggles.
  - Pending tone, at wrap: half_max<=pend_max and pend_v<=0. The new period starts with the next half-cycle, so no runt pulse.
  - Pending tone, active_o=0: apply on the next cycle. half_max<=pend_max, half_cnt<=0, sq_o<=1, active_o<=1.
  - Pending silence, at the next wrap where sq_o would become 0: force sq_o=0, active_o<=0, counter halted. A high phase is never truncated.
  - Already silent and silence requested: no change.
- Volume gating:
  - car is a free-running 10-bit counter.
  - duty = {vol_i,7'b0}.
  - pwm_o = sq_o & (car < duty), registered (1-cycle latency).
  - vol_i=0 gives pwm_o=0 constantly.
  - vol_i=7 gives 896/1024 duty during high phases.
- Arithmetic:
  - Quotient truncates.
  - The 33-bit divisor prevents overflow of 2*tone.
  - Maximum half_max is CLK_HZ/2 (tone=1).

Optional Feature:
- Macro: SOFT_START_EN.
- Defined:
  - An internal eff_vol (3 bits) replaces vol_i in the duty calculation.
  - eff_vol resets to 0 whenever active_o rises.
  - eff_vol increments by 1 every RAMP_CYC cycles until it equals vol_i.
  - If vol_i drops below eff_vol, eff_vol tracks it immediately.
- Undefined: eff_vol = vol_i combinationally; no ramp logic is synthesised.

Test Plan:
- Reset with tone_i=262, then release rst_n -> busy_o high for 32 cycles; half_max=190839; active_o=1; sq_o period 381678 cycles.
- While playing 262, switch tone_i to 440 mid-half-period -> the current half-period completes at 190839 cycles; subsequent half-periods are 113636; no sq_o pulse shorter than 113636.
- tone_i=20000 while playing -> sq_o stays high to the end of its half-period, then holds 0; active_o=0; busy_o never asserts.
- tone_i toggled 262->294->262 at 10-cycle spacing -> divider restarts each time; final half_max=190839; pend_v asserts exactly 33 cycles after the last change.
- vol_i=4 with sq_o high -> pwm_o high for 512 of every 1024 cycles; vol_i=0 -> pwm_o=0 always.
- rst_n pulsed low during DIV -> all outputs 0 immediately; after release, the divider restarts on the present tone_i.
- SOFT_START_EN build, vol_i=7, RAMP_CYC=16 -> eff_vol steps 0..7 at 16-cycle intervals after active_o rises.

Source files
------------

// File: rtl/tone_synth.sv
// Square-wave tone generator: Hz -> half-period via a serial divider, edge-aligned retune, PWM volume.
// Optional SOFT_START_EN adds a volume ramp that restarts each time a tone begins.
module tone_synth #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int SILENCE_HZ = 20000
`ifdef SOFT_START_EN
   ,parameter int RAMP_CYC  = 1_000_000
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] tone_i,
   input  logic [2:0]  vol_i,
   output logic        pwm_o,
   output logic        sq_o,
   output logic        active_o,
   output logic        busy_o
);
   localparam logic [31:0] CLK_W = 32'(CLK_HZ);
   localparam logic [31:0] SIL_W = 32'(SILENCE_HZ);

   typedef enum logic {IDLE, DIV} state_t;

   state_t      state_q;
   logic [31:0] tone_q;
   logic        req_q, pend_silent_q, pend_v_q;
   logic [31:0] pend_max_q, half_cnt_q, half_max_q;
   logic        sq_q, active_q;
   logic [32:0] div_den_q, div_rem_q;
   logic [31:0] div_num_q, div_quo_q;
   logic [4:0]  div_cnt_q;
   logic [9:0]  car_q;
   logic        pwm_q;

   logic        silent_w, ge_w;
   logic [33:0] rem_shift_w;
   logic [32:0] rem_d;
   logic [31:0] quo_d;
   logic [2:0]  eff_vol_w;
   logic [9:0]  duty_w;

   assign silent_w    = (tone_i == 32'd0) || (tone_i >= SIL_W);
   assign rem_shift_w = {div_rem_q, div_num_q[31]};
   assign ge_w        = rem_shift_w >= {1'b0, div_den_q};
   assign rem_d       = ge_w ? 33'(rem_shift_w - {1'b0, div_den_q}) : rem_shift_w[32:0];
   assign quo_d       = {div_quo_q[30:0], ge_w};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         tone_q        <= '0;
         req_q         <= 1'b0;
         pend_silent_q <= 1'b0;
         pend_v_q      <= 1'b0;
         pend_max_q    <= '0;
         half_cnt_q    <= '0;
         half_max_q    <= '0;
         sq_q          <= 1'b0;
         active_q      <= 1'b0;
         div_den_q     <= '0;
         div_rem_q     <= '0;
         div_num_q     <= '0;
         div_quo_q     <= '0;
         div_cnt_q     <= '0;
      end else begin
         // Wave generator: retune and silence only at half-period boundaries.
         if (active_q) begin
            if (half_cnt_q == half_max_q - 32'd1) begin
               half_cnt_q <= '0;
               if (pend_silent_q && sq_q) begin
                  sq_q          <= 1'b0;
                  active_q      <= 1'b0;
                  pend_silent_q <= 1'b0;
               end else begin
                  sq_q <= ~sq_q;
                  if (pend_v_q) begin
                     half_max_q <= pend_max_q;
                     pend_v_q   <= 1'b0;
                  end
               end
            end else begin
               half_cnt_q <= half_cnt_q + 32'd1;
            end
         end else if (pend_v_q) begin
            half_max_q <= pend_max_q;
            half_cnt_q <= '0;
            sq_q       <= 1'b1;
            active_q   <= 1'b1;
            pend_v_q   <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (req_q) begin
                  state_q   <= DIV;
                  req_q     <= 1'b0;
                  div_den_q <= {tone_q, 1'b0};
                  div_num_q <= CLK_W;
                  div_rem_q <= '0;
                  div_quo_q <= '0;
                  div_cnt_q <= 5'd31;
               end
            end
            DIV: begin
               div_rem_q <= rem_d;
               div_quo_q <= quo_d;
               div_num_q <= {div_num_q[30:0], 1'b0};
               div_cnt_q <= div_cnt_q - 5'd1;
               if (div_cnt_q == 5'd0) begin
                  pend_max_q <= (quo_d == 32'd0) ? 32'd1 : quo_d;
                  pend_v_q   <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // A new request overrides any in-flight or just-finished division.
         if (tone_i != tone_q) begin
            tone_q        <= tone_i;
            pend_v_q      <= 1'b0;
            state_q       <= IDLE;
            req_q         <= ~silent_w;
            pend_silent_q <= silent_w;
         end
      end
   end

`ifdef SOFT_START_EN
   localparam logic [31:0] RAMP_LAST = 32'(RAMP_CYC - 1);
   logic [2:0]  eff_vol_q;
   logic [31:0] ramp_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eff_vol_q  <= '0;
         ramp_cnt_q <= '0;
      end else if (!active_q && pend_v_q) begin
         eff_vol_q  <= '0;
         ramp_cnt_q <= '0;
      end else if (vol_i < eff_vol_q) begin
         eff_vol_q  <= vol_i;
         ramp_cnt_q <= '0;
      end else if (vol_i > eff_vol_q) begin
         if (ramp_cnt_q == RAMP_LAST) begin
            eff_vol_q  <= eff_vol_q + 3'd1;
            ramp_cnt_q <= '0;
         end else begin
            ramp_cnt_q <= ramp_cnt_q + 32'd1;
         end
      end
   end
   assign eff_vol_w = eff_vol_q;
`else
   assign eff_vol_w = vol_i;
`endif

   assign duty_w = {eff_vol_w, 7'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         car_q <= car_q + 10'd1;
         pwm_q <= sq_q & (car_q < duty_w);
      end
   end

   assign pwm_o    = pwm_q;
   assign sq_o     = sq_q;
   assign active_o = active_q;
   assign busy_o   = (state_q == DIV);
endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth, run with CLK_HZ scaled to 1 MHz so periods stay short.
module tb_tone_synth;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] tone_i;
   logic [2:0]  vol_i;
   logic        pwm_o, sq_o, active_o, busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   int busy_total = 0;

   // 1 MHz clock: 262 Hz -> 1908, 294 Hz -> 1700, 440 Hz -> 1136 cycles per half-period.
   tone_synth #(.CLK_HZ(1_000_000), .SILENCE_HZ(20000)) dut (
      .clk(clk), .rst_n(rst_n), .tone_i(tone_i), .vol_i(vol_i),
      .pwm_o(pwm_o), .sq_o(sq_o), .active_o(active_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (busy_o === 1'b1) busy_total++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic wait_sq(input string tag, input logic lvl);
      int n = 0;
      while (sq_o !== lvl && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(sq_o === lvl), 64'd1);
   endtask

   task automatic phase_len(output int len);
      logic lvl = sq_o;
      len = 0;
      while (sq_o === lvl && len < 5000) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic pwm_count(input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         if (pwm_o === 1'b1) hi++;
      end
   endtask

   // Steps from the cycle a tone was applied until sq_o rises, also counting busy cycles.
   task automatic start_latency(output int n, output int bc);
      n = 0;
      bc = 0;
      while (sq_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
         if (busy_o === 1'b1) bc++;
      end
   endtask

   initial begin
      int len, hi, n, bc, b0;
      rst_n  = 1'b0;
      tone_i = 32'd262;
      vol_i  = 3'd4;
      repeat (3) @(negedge clk);
      chk("rst_sq", sq_o, 0);
      chk("rst_pwm", pwm_o, 0);
      chk("rst_active", active_o, 0);
      chk("rst_busy", busy_o, 0);

      // Start-up on 262 Hz: 32 busy cycles, first edge 35 cycles after release.
      rst_n = 1'b1;
      start_latency(n, bc);
      chk("start_lat_262", n, 35);
      chk("start_busy_262", bc, 32);
      chk("active_on", active_o, 1);
      phase_len(len); chk("hi_262", len, 1908);
      phase_len(len); chk("lo_262", len, 1908);

      // Retune to 440 mid-half-period: current half finishes at the old length.
      repeat (500) @(negedge clk);
      tone_i = 32'd440;
      phase_len(len); chk("hi_switch_262", 500 + len, 1908);
      phase_len(len); chk("lo_440", len, 1136);
      phase_len(len); chk("hi_440", len, 1136);

      // Volume gating over 1024-cycle windows inside a phase.
      pwm_count(1024, hi); chk("pwm_low_phase", hi, 0);
      wait_sq("reach_hi_v4", 1'b1);
      pwm_count(1024, hi); chk("pwm_vol4", hi, 512);
      vol_i = 3'd7;
      wait_sq("reach_lo_v7", 1'b0);
      wait_sq("reach_hi_v7", 1'b1);
      pwm_count(1024, hi); chk("pwm_vol7", hi, 896);
      vol_i = 3'd0;
      wait_sq("reach_lo_v0", 1'b0);
      wait_sq("reach_hi_v0", 1'b1);
      pwm_count(1024, hi); chk("pwm_vol0", hi, 0);
      vol_i = 3'd4;

      // Silence request: the high phase runs to completion, then output holds low.
      wait_sq("reach_lo_sil", 1'b0);
      wait_sq("reach_hi_sil", 1'b1);
      repeat (100) @(negedge clk);
      b0 = busy_total;
      tone_i = 32'd20000;
      phase_len(len); chk("hi_to_silence", 100 + len, 1136);
      hi = 0;
      repeat (3000) begin
         @(negedge clk);
         if (sq_o !== 1'b0) hi++;
      end
      chk("silent_sq_hi", hi, 0);
      chk("silent_active", active_o, 0);
      chk("silent_busy", busy_total - b0, 0);

      // Rapid retunes: only the last request counts, latency from the last change.
      tone_i = 32'd262;
      repeat (10) @(negedge clk);
      tone_i = 32'd294;
      repeat (10) @(negedge clk);
      tone_i = 32'd262;
      start_latency(n, bc);
      chk("toggle_lat", n, 35);
      chk("toggle_busy", bc, 32);
      phase_len(len); chk("toggle_hi_262", len, 1908);

      // Reset in the middle of a division clears everything at once.
      wait_sq("reach_hi_rst", 1'b1);
      tone_i = 32'd440;
      repeat (10) @(negedge clk);
      chk("busy_mid_div", busy_o, 1);
      chk("sq_before_rst", sq_o, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_sq", sq_o, 0);
      chk("rst_async_active", active_o, 0);
      chk("rst_async_busy", busy_o, 0);
      chk("rst_async_pwm", pwm_o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_latency(n, bc);
      chk("restart_lat_440", n, 35);
      chk("restart_busy_440", bc, 32);
      phase_len(len); chk("restart_hi_440", len, 1136);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
